sram_ctrl: RTL and testbench

//  Parametrised multi-bank asynchronous SRAM controller; successor to the fixed
//  two-chip, zero-wait SRAM path. Sits between the bus module's ram_* port and
//  the board SRAMs.

---
 rtl/sram_ctrl_pkg.sv | 15 +
 rtl/sram_byte_lanes.sv | 18 +
 rtl/sram_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_sram_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared FSM state encoding and elaboration-time helpers for the SRAM controller.
package sram_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WS, S_WP, S_WH, S_TURN} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/sram_byte_lanes.sv
// sram_byte_lanes: lane enables, write-data replication and read-data alignment for a 16-bit SRAM.
module sram_byte_lanes (
  input  logic        i_byte_op,
  input  logic        i_a0,
  input  logic [15:0] i_data,
  input  logic [15:0] i_dq,
  output logic        o_ub_n,
  output logic        o_lb_n,
  output logic [15:0] o_wdata,
  output logic [15:0] o_rdata
);
  always_comb begin
    o_ub_n  = i_byte_op & ~i_a0;
    o_lb_n  = i_byte_op & i_a0;
    o_wdata = i_byte_op ? {2{i_data[7:0]}} : i_data;
    o_rdata = !i_byte_op ? i_dq : {8'h00, i_a0 ? i_dq[15:8] : i_dq[7:0]};
  end
endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: multi-bank asynchronous SRAM controller with wait states, registered strobes and turnaround.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int RAM_A_W = 18,
  parameter int NBANKS  = 2,
  parameter int ADDR_W  = 22,
  parameter int WAIT_RD = 2,
  parameter int WAIT_WR = 2,
  parameter int TURN    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [15:0]          data_in,
  output logic [15:0]          data_out,
  input  logic                 rd,
  input  logic                 wr,
  input  logic                 byte_op,
  output logic                 ack,
  output logic                 err,
  output logic [RAM_A_W-1:0]   ram_a,
  output logic                 ram_oe_n,
  output logic                 ram_we_n,
  output logic [NBANKS-1:0]    ram_ce_n,
  output logic [NBANKS-1:0]    ram_ub_n,
  output logic [NBANKS-1:0]    ram_lb_n,
  output logic [16*NBANKS-1:0] ram_dq_o,
  output logic [NBANKS-1:0]    ram_dq_oe,
  input  logic [16*NBANKS-1:0] ram_dq_i
);
  localparam int BANK_W = clog2(NBANKS);
  localparam int BW = (BANK_W > 0) ? BANK_W : 1;
  localparam int CW = clog2(max3(WAIT_RD, WAIT_WR, TURN) + 1);
  localparam logic [CW-1:0] C_RD = CW'(WAIT_RD - 1);
  localparam logic [CW-1:0] C_WR = CW'(WAIT_WR - 1);
  localparam logic [CW-1:0] C_TURN = CW'(TURN);
  localparam logic [CW-1:0] C_TURN1 = CW'((TURN > 0) ? TURN - 1 : 0);
  localparam logic [63:0] LIMIT = 64'(NBANKS) << (RAM_A_W + 1);

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [BW-1:0]         r_bank;
  logic                  r_byte;
  logic                  r_a0;
  logic [15:0]           r_data_out;
  logic                  r_ack;
  logic                  r_err;
  logic [RAM_A_W-1:0]    r_a;
  logic                  r_oe_n;
  logic                  r_we_n;
  logic [NBANKS-1:0]     r_ce_n;
  logic [NBANKS-1:0]     r_ub_n;
  logic [NBANKS-1:0]     r_lb_n;
  logic [16*NBANKS-1:0]  r_dq_o;
  logic [NBANKS-1:0]     r_dq_oe;

  logic [BW-1:0]         w_bank;
  logic [NBANKS-1:0]     w_sel;
  logic [16*NBANKS-1:0]  w_dq_mask;
  logic                  w_idle;
  logic                  w_range_err;
  logic                  w_ub_n;
  logic                  w_lb_n;
  logic [15:0]           w_wdata;
  logic [15:0]           w_rdata;
  logic [15:0]           w_dq_sel;

  generate
    if (BANK_W > 0) begin : g_bank
      assign w_bank = addr[RAM_A_W+1 +: BW];
    end else begin : g_nobank
      assign w_bank = '0;
    end
    for (genvar i = 0; i < NBANKS; i++) begin : g_mask
      assign w_dq_mask[16*i +: 16] = {16{w_sel[i]}};
    end
  endgenerate

  assign w_sel       = NBANKS'(1) << w_bank;
  assign w_idle      = r_state == S_IDLE;
  assign w_range_err = 64'(addr) >= LIMIT;
  assign w_dq_sel    = ram_dq_i[{r_bank, 4'b0000} +: 16];

  // Live request fields steer the lanes while idle; latched fields align read data later.
  sram_byte_lanes u_lanes (
    .i_byte_op (w_idle ? byte_op : r_byte),
    .i_a0      (w_idle ? addr[0] : r_a0),
    .i_data    (data_in),
    .i_dq      (w_dq_sel),
    .o_ub_n    (w_ub_n),
    .o_lb_n    (w_lb_n),
    .o_wdata   (w_wdata),
    .o_rdata   (w_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bank     <= '0;
      r_byte     <= 1'b0;
      r_a0       <= 1'b0;
      r_data_out <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_a        <= '0;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_ce_n     <= '1;
      r_ub_n     <= '1;
      r_lb_n     <= '1;
      r_dq_o     <= '0;
      r_dq_oe    <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if ((rd && wr) || ((rd || wr) && w_range_err)) begin
            r_err   <= 1'b1;
            r_state <= S_TURN;
            r_cnt   <= C_TURN;
          end else if (rd || wr) begin
            r_a    <= addr[RAM_A_W:1];
            r_bank <= w_bank;
            r_byte <= byte_op;
            r_a0   <= addr[0];
            r_ce_n <= ~w_sel;
            r_ub_n <= {NBANKS{w_ub_n}} | ~w_sel;
            r_lb_n <= {NBANKS{w_lb_n}} | ~w_sel;
            if (rd) begin
              r_oe_n  <= 1'b0;
              r_state <= S_RD;
              r_cnt   <= C_RD;
            end else begin
              r_dq_o  <= {NBANKS{w_wdata}} & w_dq_mask;
              r_dq_oe <= w_sel;
              r_state <= S_WS;
            end
          end
        end
        S_RD: begin
          if (r_cnt == '0) begin
            r_data_out <= w_rdata;
            r_ack      <= 1'b1;
            r_oe_n     <= 1'b1;
            r_ce_n     <= '1;
            r_ub_n     <= '1;
            r_lb_n     <= '1;
            r_state    <= S_TURN;
            r_cnt      <= C_TURN;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WS: begin
          r_we_n  <= 1'b0;
          r_state <= S_WP;
          r_cnt   <= C_WR;
        end
        S_WP: begin
          if (r_cnt == '0) begin
            r_we_n  <= 1'b1;
            r_ack   <= 1'b1;
            r_state <= S_WH;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WH: begin
          r_ce_n  <= '1;
          r_ub_n  <= '1;
          r_lb_n  <= '1;
          r_dq_o  <= '0;
          r_dq_oe <= '0;
          r_state <= (TURN == 0) ? S_IDLE : S_TURN;
          r_cnt   <= C_TURN1;
        end
        S_TURN: begin
          r_state <= (r_cnt == '0) ? S_IDLE : S_TURN;
          r_cnt   <= (r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_out  = r_data_out;
  assign ack       = r_ack;
  assign err       = r_err;
  assign ram_a     = r_a;
  assign ram_oe_n  = r_oe_n;
  assign ram_we_n  = r_we_n;
  assign ram_ce_n  = r_ce_n;
  assign ram_ub_n  = r_ub_n;
  assign ram_lb_n  = r_lb_n;
  assign ram_dq_o  = r_dq_o;
  assign ram_dq_oe = r_dq_oe;
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: randomized scoreboard bench for sram_ctrl against a behavioural SRAM and memory model.
module tb_sram_ctrl;
  localparam int WAIT_RD = 2;
  localparam int WAIT_WR = 2;
  localparam int TURN    = 1;
  localparam int WORDS   = 262144;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [21:0] addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic        byte_op = 1'b0;
  logic        ack;
  logic        err;
  logic [17:0] ram_a;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic [1:0]  ram_ce_n;
  logic [1:0]  ram_ub_n;
  logic [1:0]  ram_lb_n;
  logic [31:0] ram_dq_o;
  logic [1:0]  ram_dq_oe;
  logic [31:0] ram_dq_i;

  always #5 clk = ~clk;

  sram_ctrl #(
    .RAM_A_W(18), .NBANKS(2), .ADDR_W(22),
    .WAIT_RD(WAIT_RD), .WAIT_WR(WAIT_WR), .TURN(TURN)
  ) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .data_in(data_in), .data_out(data_out),
    .rd(rd), .wr(wr), .byte_op(byte_op), .ack(ack), .err(err), .ram_a(ram_a),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_ce_n(ram_ce_n), .ram_ub_n(ram_ub_n),
    .ram_lb_n(ram_lb_n), .ram_dq_o(ram_dq_o), .ram_dq_oe(ram_dq_oe), .ram_dq_i(ram_dq_i)
  );

  typedef struct {
    bit          is_err;
    bit          is_rd;
    bit          chk_lat;
    int          start;
    logic [15:0] data;
    logic [1:0]  ce;
    logic [1:0]  ub;
    logic [1:0]  lb;
    logic [31:0] dq;
    logic [17:0] a;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_gap = 0;
  bit   [15:0] sram [2][WORDS];
  bit   [15:0] mdl  [2][WORDS];
  logic [15:0] last_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input int b, input int k);
    return 16'(((b * 64 + k) * 40503) ^ 23130);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Behavioural asynchronous SRAM: reads while ce/oe low, writes enabled lanes while we low.
  assign ram_dq_i[15:0]  = (!ram_ce_n[0] && !ram_oe_n) ? sram[0][ram_a] : 16'hDEAD;
  assign ram_dq_i[31:16] = (!ram_ce_n[1] && !ram_oe_n) ? sram[1][ram_a] : 16'hBEEF;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < 64; k++) sram[b][k] = init_val(b, k);
    sram[0][512] = 16'o123456;
    forever begin
      @(negedge clk);
      for (int b = 0; b < 2; b++)
        if (!ram_we_n && !ram_ce_n[b] && ram_dq_oe[b]) begin
          if (!ram_lb_n[b]) sram[b][ram_a][7:0] = ram_dq_o[16*b +: 8];
          if (!ram_ub_n[b]) sram[b][ram_a][15:8] = ram_dq_o[16*b+8 +: 8];
        end
    end
  end

  initial begin
    int   oe_lo, we_lo, oe_cnt, hi_run;
    bit   prev_ack, prev_err;
    exp_t e;
    oe_lo = 0; we_lo = 0; oe_cnt = 0; hi_run = 0; prev_ack = 0; prev_err = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        sb.delete();
        oe_lo = 0; we_lo = 0; oe_cnt = 0; prev_ack = 0; prev_err = 0;
        chk("no_resp_in_reset", {ack, err}, 0);
        continue;
      end
      if (prev_ack) chk("ack_one_cycle", ack, 0);
      if (prev_err) chk("err_one_cycle", err, 0);
      prev_ack = ack;
      prev_err = err;
      if (!ram_oe_n) begin
        if (hi_run > 0) last_gap = hi_run;
        hi_run = 0;
      end else hi_run++;
      if (sb.size() > 0) begin
        e = sb[0];
        if (e.is_err) chk("err_no_ce", ram_ce_n, 2'b11);
        else if (ram_ce_n != 2'b11) begin
          chk("ce_n", ram_ce_n, e.ce);
          chk("ub_n", ram_ub_n, e.ub);
          chk("lb_n", ram_lb_n, e.lb);
          chk("ram_a", ram_a, e.a);
          if (e.is_rd) chk("rd_we_dqoe", {ram_we_n, ram_dq_oe}, 3'b100);
          else begin
            chk("wr_oe_n", ram_oe_n, 1);
            chk("wr_dq_o", ram_dq_o, e.dq);
            chk("wr_dq_oe", ram_dq_oe, 2'(~e.ce));
          end
        end
        if (!ram_oe_n) oe_lo++;
        if (!ram_we_n) we_lo++;
        if (ram_dq_oe != 2'b00) oe_cnt++;
      end
      if (ack || err) begin
        if (sb.size() == 0) chk("unexpected_resp", {ack, err}, 0);
        else begin
          e = sb.pop_front();
          chk("resp_kind", {ack, err}, e.is_err ? 2'b01 : 2'b10);
          if (e.chk_lat)
            chk("latency", cyc - e.start, e.is_err ? 1 : (e.is_rd ? WAIT_RD + 1 : WAIT_WR + 2));
          chk("data_out", data_out, e.data);
          if (!e.is_err && e.is_rd) chk("oe_low_cycles", oe_lo, WAIT_RD);
          if (!e.is_err && !e.is_rd) begin
            chk("we_low_cycles", we_lo, WAIT_WR);
            chk("dq_oe_cycles", oe_cnt, WAIT_WR + 2);
          end
        end
        oe_lo = 0; we_lo = 0; oe_cnt = 0;
      end
    end
  end

  task automatic do_req(input bit r, input bit w, input logic [21:0] a, input logic [15:0] d,
                        input bit bo, input bit lat, input bit gap);
    exp_t e;
    int   bank, word;
    bit   got;
    logic [15:0] m;
    bank = int'(a[19]);
    word = int'(a[18:1]);
    e.is_err = (r && w) || (a >= 22'h100000);
    e.is_rd = r;
    e.chk_lat = lat;
    e.ce = 2'b11;
    e.ce[bank] = 1'b0;
    e.ub = 2'b11;
    e.lb = 2'b11;
    if (!bo || a[0]) e.ub[bank] = 1'b0;
    if (!bo || !a[0]) e.lb[bank] = 1'b0;
    e.dq = '0;
    e.dq[16*bank +: 16] = bo ? {d[7:0], d[7:0]} : d;
    e.a = a[18:1];
    if (!e.is_err) begin
      m = mdl[bank][word];
      if (r) last_rd = bo ? {8'h00, a[0] ? m[15:8] : m[7:0]} : m;
      else if (!bo) mdl[bank][word] = d;
      else if (a[0]) mdl[bank][word] = {d[7:0], m[7:0]};
      else mdl[bank][word] = {m[15:8], d[7:0]};
    end
    e.data = last_rd;
    @(negedge clk);
    e.start = cyc;
    sb.push_back(e);
    rd = r; wr = w; addr = a; data_in = d; byte_op = bo;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ack || err) begin
        got = 1;
        break;
      end
    end
    chk("resp_timeout", got, 1);
    @(posedge clk);
    #1;
    rd = 0; wr = 0;
    if (gap) repeat (TURN + 2) @(negedge clk);
  endtask

  initial begin
    bit got;
    bit imm;
    int op, bank, word;
    logic [21:0] a;
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < 64; k++) mdl[b][k] = init_val(b, k);
    mdl[0][512] = 16'o123456;
    repeat (3) @(negedge clk);
    chk("rst_n_outs", {ram_oe_n, ram_we_n, ram_ce_n, ram_ub_n, ram_lb_n}, 8'hFF);
    chk("rst_oe_ack_err", {ram_dq_oe, ack, err}, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_ram_a", ram_a, 0);
    chk("rst_dq_o", ram_dq_o, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    do_req(1, 0, 22'o002000, 16'h0000, 0, 1, 1);
    do_req(1, 0, 22'o002001, 16'h0000, 1, 1, 1);
    do_req(0, 1, 22'o002001, 16'h005A, 1, 1, 1);
    chk("sram_after_byte_wr", sram[0][512], mdl[0][512]);
    do_req(1, 0, 22'o002000, 16'h0000, 0, 1, 1);
    do_req(1, 0, 22'h100000, 16'h0000, 0, 1, 1);
    do_req(1, 1, 22'o002000, 16'h1111, 0, 1, 1);
    do_req(1, 0, 22'h080000, 16'h0000, 0, 1, 1);
    do_req(1, 0, 22'h000004, 16'h0000, 0, 1, 0);
    do_req(1, 0, 22'h080006, 16'h0000, 0, 0, 1);
    chk("b2b_oe_gap", last_gap >= TURN + 1, 1);

    // Reset asserted while we_n is low must drop strobes at once and produce no response.
    a = {2'b00, 1'b1, 18'd70, 1'b0};
    @(negedge clk);
    rd = 0; wr = 1; addr = a; data_in = 16'h1234; byte_op = 0;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!ram_we_n) begin
        got = 1;
        break;
      end
    end
    chk("wp_reached", got, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_strobes", {ram_we_n, ram_ce_n, ram_oe_n}, 4'hF);
    chk("rst_mid_dq_oe", ram_dq_oe, 0);
    wr = 0;
    last_rd = '0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    do_req(1, 0, 22'o002000, 16'h0000, 0, 1, 1);

    imm = 0;
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 19);
      bank = $urandom_range(0, 1);
      word = $urandom_range(0, 63);
      a = {2'b00, 1'(bank), 18'(word), 1'($urandom_range(0, 1))};
      if (op == 19) a[21:20] = 2'($urandom_range(1, 3));
      got = ($urandom_range(0, 3) == 0);
      do_req(op < 9 || op >= 18, (op >= 9 && op < 18) || op == 18, a, 16'($urandom),
             1'($urandom_range(0, 1)), !imm, !got);
      imm = got;
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "time limit");
  end
endmodule
